wishbone_dev_classic: RTL and testbench
=======================================

# wishbone_dev_classic

Device-side adapter for a Wishbone B4 *classic* (non-pipelined) bus, plus the `wishbone_classic` interface bundle it connects to. It turns a host's `cyc_i`/`stb_i` strobe into a single-cycle `request` pulse for a simple peripheral. It exposes write data to that peripheral and generates a registered `ack_o` back to the host. Peripherals such as LED or GPIO register blocks instantiate it, with the interface in a shared bus layer.

## Interface
Parameters (module and interface; the two must match):
- `ADDR_WIDTH`, 32, width of `adr_i`.
- `DATA_WIDTH`, 32, width of `dat_i`/`dat_o`/`write_data`/`read_data`; `sel_i` is `DATA_WIDTH/8` bits.

Interface `wishbone_classic`:
- Ports: `clk_i`, `rst_i`.
- Internal signals: `cyc_i`, `stb_i`, `we_i`, `adr_i`, `dat_i`, `sel_i`, `dat_o`, `ack_o`.
- Modports: `device` (drives `dat_o`, `ack_o`) and `host` (drives the rest).

Module ports:
- `wb`, interface port `wishbone_classic.device`. Carries `wb.clk_i` (the single clock) and `wb.rst_i` (synchronous, active-high reset).
- `ack`, input, 1 bit: peripheral ready to complete; tie to 1 for zero-wait-state devices.
- `read_data`, input, DATA_WIDTH bits: peripheral read value; port default `'0`.
- `request`, output, 1 bit: one-cycle pulse, a transfer is accepted this cycle.
- `write_data`, output, DATA_WIDTH bits: equals `wb.dat_i` (combinational).
- `address`, output, ADDR_WIDTH bits: equals `wb.adr_i`.
- `write_enable`, output, 1 bit: equals `wb.we_i`.
- `byte_sel`, output, DATA_WIDTH/8 bits: equals `wb.sel_i`.

## Operation
- `request = cyc_i & stb_i & ~ack_o & ack & ~rst_i`, combinational.
- `ack_q` is a register: it loads `request` every clock and clears on `rst_i`.
- `ack_o = ack_q & cyc_i & stb_i`. The gate suppresses the acknowledge if the host aborts.
- `dat_o` is a register: it loads `read_data` when `request` is high and is cleared on reset. It is driven to 0 whenever `ack_o` is low.
- Reads and writes are handled identically. The peripheral qualifies the transfer with `write_enable`.
- The peripheral must sample `write_data` in the `request` cycle. The bus value is only guaranteed then.

## Timing
- Reset values: `ack_q = 0`, `ack_o = 0`, `dat_o = 0`, `request = 0` while `rst_i` is high.
- Zero wait states (`ack = 1`):
  - `request` is asserted in the first cycle of `cyc_i & stb_i`.
  - `ack_o` is asserted in the next cycle, for exactly one cycle.
- Latency is fixed at 1 cycle from request to `ack_o`.
- Back-to-back: if the host keeps `stb_i` high after `ack_o`, the next `request` fires the cycle after `ack_o`. Maximum throughput is one transfer per 2 cycles.
- Wait states: while `ack = 0`, no `request` and no `ack_o` are issued. `request` fires in the first cycle `ack` is high.
- Host abort: if `cyc_i` or `stb_i` drops in the ack cycle, `ack_o` stays 0. `ack_q` then self-clears next cycle.
- Reset mid-transfer: `ack_o` is low from the cycle after `rst_i` is sampled. Any pending acknowledge is discarded.
- Exactly one `request` per classic bus cycle. A peripheral updating on `request` therefore holds `$past(dat_i)` the cycle after any accepted strobe.

## Configuration
- `WB_DEV_ASSERT_EN` defined compiles in concurrent assertions and covers, clocked on `wb.clk_i` and disabled during `wb.rst_i`:
  - `ack_o` implies `cyc_i & stb_i`.
  - `ack_o` implies no `request` in the same cycle.
  - `ack_o` is never high for 2 consecutive cycles.
  - `request |=> ack_o` when `cyc_i & stb_i` is held.
  - Cover: a write transfer followed by 10 idle cycles.
- Undefined: no assertion or cover code is elaborated. Functional RTL is identical either way.

## Structure
- Package `wishbone_pkg` holds `WB_ADDR_WIDTH`/`WB_DATA_WIDTH` defaults and typedefs `wb_addr_t`, `wb_data_t`, `wb_sel_t`.
- Interface `wishbone_classic` is in its own file, with modports `device`/`host`.
- `wishbone_dev_classic` is a single module with no sub-modules.

## Test plan
- Reset: hold `rst_i` high 3 cycles with `cyc_i = stb_i = 1`. Required: `ack_o = 0`, `request = 0`, `dat_o = 0` throughout.
- Single write, `ack = 1`, `dat_i = 0xA5`, `we_i = 1`:
  - `request = 1` and `write_data = 0xA5` in cycle 0.
  - `ack_o = 1` in cycle 1 only.
  - A register fed by `request` holds 0xA5 in cycle 1.
- Wait states: hold `ack = 0` for 4 cycles then raise it. Required: `request` in cycle 4, `ack_o` in cycle 5, neither earlier.
- Back-to-back: keep `stb_i` high for 6 cycles. Required: `request` in cycles 0, 2, 4 and `ack_o` in cycles 1, 3, 5.
- Read: `read_data = 0x1234`, `we_i = 0`. Required: `dat_o = 0x1234` while `ack_o = 1`, and 0 in the following idle cycle.
- Abort: drop `cyc_i` in the cycle after `request`. Required: `ack_o` stays 0, and the next strobe is accepted normally.

Source files
------------

// File: rtl/wishbone_pkg.sv
// wishbone_pkg
//   Shared Wishbone definitions for the bus layer and the devices hanging
//   off it: default address/data widths and the matching vector typedefs.
//   No ports; imported by wishbone_classic and wishbone_dev_classic.
package wishbone_pkg;

  localparam int WB_ADDR_WIDTH = 32;
  localparam int WB_DATA_WIDTH = 32;
  localparam int WB_SEL_WIDTH  = WB_DATA_WIDTH / 8;

  typedef logic [WB_ADDR_WIDTH-1:0] wb_addr_t;
  typedef logic [WB_DATA_WIDTH-1:0] wb_data_t;
  typedef logic [WB_SEL_WIDTH-1:0]  wb_sel_t;

endpackage : wishbone_pkg

// File: rtl/wishbone_classic.sv
// wishbone_classic
//   Signal bundle for a Wishbone B4 classic (non-pipelined) bus segment.
//   Ports:
//     clk_i  - bus clock
//     rst_i  - synchronous, active-high bus reset
//   Signals (named from the device's point of view):
//     cyc_i, stb_i, we_i, adr_i, dat_i, sel_i  - driven by the host
//     dat_o, ack_o                             - driven by the device
//   Modports:
//     device - drives dat_o/ack_o, observes everything else
//     host   - drives cyc/stb/we/adr/dat_i/sel, observes dat_o/ack_o
interface wishbone_classic
  import wishbone_pkg::*;
#(
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH = WB_DATA_WIDTH
) (
  input logic clk_i,
  input logic rst_i
);

  logic                    cyc_i;
  logic                    stb_i;
  logic                    we_i;
  logic [ADDR_WIDTH-1:0]   adr_i;
  logic [DATA_WIDTH-1:0]   dat_i;
  logic [DATA_WIDTH/8-1:0] sel_i;
  logic [DATA_WIDTH-1:0]   dat_o;
  logic                    ack_o;

  modport device (
    input  clk_i, rst_i, cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
    output dat_o, ack_o
  );

  modport host (
    input  clk_i, rst_i, dat_o, ack_o,
    output cyc_i, stb_i, we_i, adr_i, dat_i, sel_i
  );

endinterface : wishbone_classic

// File: rtl/wishbone_dev_classic.sv
// wishbone_dev_classic
//   Device-side adapter for a Wishbone B4 classic bus. Each host strobe is
//   turned into a single-cycle 'request' pulse for a simple peripheral, and
//   a registered acknowledge (with registered read data) is returned one
//   cycle later.
//   Ports:
//     wb           - wishbone_classic.device (clock wb.clk_i, sync reset wb.rst_i)
//     ack          - peripheral ready to complete (tie 1 for zero wait states)
//     read_data    - peripheral read value, captured on 'request'
//     request      - one-cycle pulse: a transfer is accepted this cycle
//     write_data   - wb.dat_i, only guaranteed valid in the 'request' cycle
//     address      - wb.adr_i
//     write_enable - wb.we_i
//     byte_sel     - wb.sel_i
//   Build option:
//     WB_DEV_ASSERT_EN - compiles in protocol assertions and a cover point.
module wishbone_dev_classic
  import wishbone_pkg::*;
#(
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH = WB_DATA_WIDTH
) (
  wishbone_classic.device          wb,
  input  logic                     ack,
  input  logic [DATA_WIDTH-1:0]    read_data = '0,
  output logic                     request,
  output logic [DATA_WIDTH-1:0]    write_data,
  output logic [ADDR_WIDTH-1:0]    address,
  output logic                     write_enable,
  output logic [DATA_WIDTH/8-1:0]  byte_sel
);

  logic                  strobe;
  logic                  ack_q;
  logic                  ack_out;
  logic [DATA_WIDTH-1:0] dat_q;

  assign strobe = wb.cyc_i & wb.stb_i;

  // The ~ack_out term blocks a second request while the current transfer
  // is being acknowledged, giving exactly one request per bus cycle and a
  // best-case rate of one transfer every two clocks.
  assign request = strobe & ~ack_out & ack & ~wb.rst_i;

  // Gating the registered acknowledge with the live strobe drops it if the
  // host abandons the cycle; ack_q then clears on its own next clock.
  assign ack_out = ack_q & strobe;

  always_ff @(posedge wb.clk_i) begin
    if (wb.rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= request;
      if (request) begin
        dat_q <= read_data;
      end
    end
  end

  // Read data is only presented on the bus alongside the acknowledge.
  assign wb.ack_o = ack_out;
  assign wb.dat_o = ack_out ? dat_q : '0;

  assign write_data   = wb.dat_i;
  assign address      = wb.adr_i;
  assign write_enable = wb.we_i;
  assign byte_sel     = wb.sel_i;

`ifdef WB_DEV_ASSERT_EN
  ack_needs_strobe_a : assert property (
    @(posedge wb.clk_i) disable iff (wb.rst_i)
    ack_out |-> strobe
  );

  ack_excludes_request_a : assert property (
    @(posedge wb.clk_i) disable iff (wb.rst_i)
    ack_out |-> !request
  );

  ack_single_cycle_a : assert property (
    @(posedge wb.clk_i) disable iff (wb.rst_i)
    ack_out |=> !ack_out
  );

  request_then_ack_a : assert property (
    @(posedge wb.clk_i) disable iff (wb.rst_i)
    request ##1 strobe |-> ack_out
  );

  write_then_idle_c : cover property (
    @(posedge wb.clk_i) disable iff (wb.rst_i)
    (request && wb.we_i) ##1 ack_out ##1 (!strobe) [*10]
  );
`endif

endmodule : wishbone_dev_classic

// File: tb/tb_wishbone_dev_classic.sv
// tb_wishbone_dev_classic
//   Self-checking bench for wishbone_dev_classic. Each cycle the bench
//   drives the host/peripheral inputs, pushes the outputs it expects for
//   that cycle onto a scoreboard queue, and pops/compares them against the
//   DUT mid-cycle on the falling edge.
module tb_wishbone_dev_classic;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  wishbone_classic #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus (
    .clk_i (clk),
    .rst_i (rst)
  );

  logic          periph_ack;
  logic [DW-1:0] periph_rdata;
  logic          request;
  logic [DW-1:0] write_data;
  logic [AW-1:0] address;
  logic          write_enable;
  logic [DW/8-1:0] byte_sel;

  wishbone_dev_classic #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .wb           (bus),
    .ack          (periph_ack),
    .read_data    (periph_rdata),
    .request      (request),
    .write_data   (write_data),
    .address      (address),
    .write_enable (write_enable),
    .byte_sel     (byte_sel)
  );

  // Stand-in peripheral register that latches the write data on request.
  logic [DW-1:0] periph_reg = '0;
  always_ff @(posedge clk) begin
    if (request) begin
      periph_reg <= write_data;
    end
  end

  typedef struct {
    string         tag;
    logic          req;
    logic          ack_o;
    logic [DW-1:0] dat_o;
    logic [DW-1:0] wdata;
    logic [AW-1:0] adr;
    logic          we;
    logic [3:0]    sel;
    logic          chk_periph;
    logic [DW-1:0] periph;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  // One bus cycle: drive inputs, queue the expected outputs, compare them
  // on the falling edge, then advance just past the next rising edge.
  task automatic applyStimulus(
    input string         tag,
    input logic          rst_v,
    input logic          cyc,
    input logic          stb,
    input logic          we,
    input logic [DW-1:0] dat,
    input logic [DW-1:0] rdata,
    input logic          pack,
    input logic          e_req,
    input logic          e_ack,
    input logic [DW-1:0] e_dat,
    input logic          chk_p,
    input logic [DW-1:0] e_p
  );
    exp_t e;
    exp_t got;
    logic [AW-1:0] adr;
    adr = 32'h0000_4000 + dat;
    rst          = rst_v;
    bus.cyc_i    = cyc;
    bus.stb_i    = stb;
    bus.we_i     = we;
    bus.adr_i    = adr;
    bus.dat_i    = dat;
    bus.sel_i    = 4'hF;
    periph_ack   = pack;
    periph_rdata = rdata;
    e.tag = tag; e.req = e_req; e.ack_o = e_ack; e.dat_o = e_dat;
    e.wdata = dat; e.adr = adr; e.we = we; e.sel = 4'hF;
    e.chk_periph = chk_p; e.periph = e_p;
    exp_q.push_back(e);
    @(negedge clk);
    got = exp_q.pop_front();
    checkOutput({got.tag, ".request"},      {31'd0, request},      {31'd0, got.req});
    checkOutput({got.tag, ".ack_o"},        {31'd0, bus.ack_o},    {31'd0, got.ack_o});
    checkOutput({got.tag, ".dat_o"},        bus.dat_o,             got.dat_o);
    checkOutput({got.tag, ".write_data"},   write_data,            got.wdata);
    checkOutput({got.tag, ".address"},      address,               got.adr);
    checkOutput({got.tag, ".write_enable"}, {31'd0, write_enable}, {31'd0, got.we});
    checkOutput({got.tag, ".byte_sel"},     {28'd0, byte_sel},     {28'd0, got.sel});
    if (got.chk_periph) begin
      checkOutput({got.tag, ".periph_reg"}, periph_reg, got.periph);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle(input string tag);
    applyStimulus(tag, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1,
                  1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    $display("[TB] starting wishbone_dev_classic bench");

    // Reset held with a live strobe: nothing may come out.
    for (int i = 0; i < 3; i++) begin
      applyStimulus($sformatf("reset%0d", i), 1'b1, 1'b1, 1'b1, 1'b1,
                    32'h77, 32'hDEAD, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    end
    idleCycle("idle0");

    // Single zero-wait write of 0xA5.
    applyStimulus("wr_c0", 1'b0, 1'b1, 1'b1, 1'b1, 32'hA5, 32'h0, 1'b1,
                  1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus("wr_c1", 1'b0, 1'b1, 1'b1, 1'b1, 32'hA5, 32'h0, 1'b1,
                  1'b0, 1'b1, 32'h0, 1'b1, 32'hA5);
    idleCycle("wr_c2");

    // Wait states: peripheral not ready for four cycles.
    for (int i = 0; i < 4; i++) begin
      applyStimulus($sformatf("ws_c%0d", i), 1'b0, 1'b1, 1'b1, 1'b1,
                    32'h5A, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    end
    applyStimulus("ws_c4", 1'b0, 1'b1, 1'b1, 1'b1, 32'h5A, 32'h0, 1'b1,
                  1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus("ws_c5", 1'b0, 1'b1, 1'b1, 1'b1, 32'h5A, 32'h0, 1'b1,
                  1'b0, 1'b1, 32'h0, 1'b1, 32'h5A);
    idleCycle("ws_c6");

    // Back-to-back: strobe held six cycles with changing data each cycle.
    // Even cycles accept; odd cycles acknowledge with the data captured
    // in the preceding cycle.
    for (int i = 0; i < 6; i++) begin
      logic odd;
      odd = (i % 2) == 1;
      applyStimulus($sformatf("b2b_c%0d", i), 1'b0, 1'b1, 1'b1, 1'b1,
                    32'h200 + 32'(i), 32'h100 + 32'(i), 1'b1,
                    !odd, odd, odd ? 32'h100 + 32'(i - 1) : 32'h0,
                    odd, 32'h200 + 32'(i - 1));
    end
    idleCycle("b2b_c6");

    // Read: read_data changes after capture to show dat_o is registered.
    applyStimulus("rd_c0", 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h1234, 1'b1,
                  1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus("rd_c1", 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'hFFFF, 1'b1,
                  1'b0, 1'b1, 32'h1234, 1'b0, 32'h0);
    applyStimulus("rd_c2", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'hFFFF, 1'b1,
                  1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Abort: host drops cyc in the acknowledge cycle, then retries.
    applyStimulus("ab_c0", 1'b0, 1'b1, 1'b1, 1'b1, 32'h33, 32'h0, 1'b1,
                  1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus("ab_c1", 1'b0, 1'b0, 1'b1, 1'b1, 32'h33, 32'h0, 1'b1,
                  1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus("ab_c2", 1'b0, 1'b1, 1'b1, 1'b1, 32'h44, 32'h0, 1'b1,
                  1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus("ab_c3", 1'b0, 1'b1, 1'b1, 1'b1, 32'h44, 32'h0, 1'b1,
                  1'b0, 1'b1, 32'h0, 1'b1, 32'h44);
    idleCycle("ab_c4");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_wishbone_dev_classic
